// File: rtl/banco_reg_sb_if.sv
// Register-bank access bus: write port, two read ports and scoreboard reservation.
interface banco_reg_sb_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned AW_BITS = 5
);
    logic               RegWrite;
    logic [AW_BITS-1:0] AW;
    logic [WIDTH-1:0]   WriteData;
    logic [AW_BITS-1:0] RA1;
    logic [AW_BITS-1:0] RA2;
    logic [WIDTH-1:0]   DR1;
    logic [WIDTH-1:0]   DR2;
    logic               Reserve;
    logic [AW_BITS-1:0] AR;
    logic               Busy1;
    logic               Busy2;
    logic               AnyBusy;

    // Datapath side: issues writes, reads and reservations.
    modport master (
        output RegWrite, AW, WriteData, RA1, RA2, Reserve, AR,
        input  DR1, DR2, Busy1, Busy2, AnyBusy
    );

    // Register bank side.
    modport slave (
        input  RegWrite, AW, WriteData, RA1, RA2, Reserve, AR,
        output DR1, DR2, Busy1, Busy2, AnyBusy
    );
endinterface

// File: rtl/banco_reg_sb.sv
// Parametrised register bank with two async read ports, one write port,
// optional r0 hardwiring, optional write-to-read bypass and a pending
// (scoreboard) bit per register for RAW hazard detection.
module banco_reg_sb #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned AW_BITS  = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    banco_reg_sb_if.slave        bus
);

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [NREG-1:0]  pend_q;
    logic [NREG-1:0]  pend_d;
    logic             wr_ok;
    logic             res_ok;

    // Writes and reservations to r0 are dropped when r0 is hardwired.
    always_comb begin
        wr_ok  = bus.RegWrite;
        res_ok = bus.Reserve;
        if (ZERO_REG != 0 && bus.AW == '0) begin
            wr_ok = 1'b0;
        end
        if (ZERO_REG != 0 && bus.AR == '0) begin
            res_ok = 1'b0;
        end
    end

    // Next state: write clears pending, a same-address reservation then re-sets it.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_d[i] = '0;
            end
            pend_d = '0;
        end else begin
            if (wr_ok) begin
                regs_d[bus.AW] = bus.WriteData;
                pend_d[bus.AW] = 1'b0;
            end
            if (res_ok) begin
                pend_d[bus.AR] = 1'b1;
            end
        end
    end

    // State registers; reset is applied through the next-state logic.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
        pend_q <= pend_d;
    end

    // Read ports: array value, overridden by bypass, overridden by hardwired r0.
    always_comb begin
        bus.DR1   = regs_q[bus.RA1];
        bus.Busy1 = pend_q[bus.RA1];
        if (BYPASS != 0 && wr_ok && bus.AW == bus.RA1) begin
            bus.DR1   = bus.WriteData;
            bus.Busy1 = 1'b0;
        end
        if (ZERO_REG != 0 && bus.RA1 == '0) begin
            bus.DR1   = '0;
            bus.Busy1 = 1'b0;
        end

        bus.DR2   = regs_q[bus.RA2];
        bus.Busy2 = pend_q[bus.RA2];
        if (BYPASS != 0 && wr_ok && bus.AW == bus.RA2) begin
            bus.DR2   = bus.WriteData;
            bus.Busy2 = 1'b0;
        end
        if (ZERO_REG != 0 && bus.RA2 == '0) begin
            bus.DR2   = '0;
            bus.Busy2 = 1'b0;
        end

        bus.AnyBusy = |pend_q;
    end

endmodule

// File: tb/tb_banco_reg_sb.sv
// Directed bench for banco_reg_sb: one instance with bypass, one without,
// both driven with identical stimulus.
module tb_banco_reg_sb;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned AW_BITS = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    banco_reg_sb_if #(.WIDTH(WIDTH), .AW_BITS(AW_BITS)) bus_b ();
    banco_reg_sb_if #(.WIDTH(WIDTH), .AW_BITS(AW_BITS)) bus_n ();

    banco_reg_sb #(.BYPASS(1)) u_byp (.clk(clk), .rst(rst), .bus(bus_b.slave));
    banco_reg_sb #(.BYPASS(0)) u_nob (.clk(clk), .rst(rst), .bus(bus_n.slave));

    typedef struct {
        bit          chk;
        bit          rst;
        bit          we;
        logic [4:0]  aw;
        logic [31:0] wd;
        bit          res;
        logic [4:0]  ar;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] dr1;
        logic [31:0] dr2;
        bit          b1;
        bit          b2;
        bit          any;
        logic [31:0] dr2n;
        bit          b2n;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input bit r, input bit we, input logic [4:0] aw, input logic [31:0] wd,
                         input bit res, input logic [4:0] ar, input logic [4:0] ra1, input logic [4:0] ra2);
        rst = r;
        bus_b.RegWrite = we; bus_b.AW = aw; bus_b.WriteData = wd;
        bus_b.Reserve = res; bus_b.AR = ar; bus_b.RA1 = ra1; bus_b.RA2 = ra2;
        bus_n.RegWrite = we; bus_n.AW = aw; bus_n.WriteData = wd;
        bus_n.Reserve = res; bus_n.AR = ar; bus_n.RA1 = ra1; bus_n.RA2 = ra2;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    //                 chk rst we aw wd res ar ra1 ra2 | dr1 dr2 b1 b2 any dr2n b2n
    function automatic vec_t mk(bit c, bit r, bit we, int aw, logic [31:0] wd, bit res, int ar,
                                int ra1, int ra2, logic [31:0] dr1, logic [31:0] dr2,
                                bit b1, bit b2, bit any, logic [31:0] dr2n, bit b2n);
        vec_t v;
        v.chk = c; v.rst = r; v.we = we; v.aw = 5'(aw); v.wd = wd; v.res = res; v.ar = 5'(ar);
        v.ra1 = 5'(ra1); v.ra2 = 5'(ra2); v.dr1 = dr1; v.dr2 = dr2; v.b1 = b1; v.b2 = b2;
        v.any = any; v.dr2n = dr2n; v.b2n = b2n;
        return v;
    endfunction

    initial begin
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0);

        vecs.push_back(mk(0,1,0, 0,32'h0,        0,0,  0, 0, 32'h0,        32'h0,        0,0,0, 32'h0,        0));
        vecs.push_back(mk(1,0,0, 0,32'h0,        0,0,  0, 0, 32'h0,        32'h0,        0,0,0, 32'h0,        0));
        vecs.push_back(mk(1,0,1, 5,32'hDEADBEEF, 1,7,  5, 7, 32'hDEADBEEF, 32'h0,        0,0,0, 32'h0,        0));
        vecs.push_back(mk(1,0,0, 0,32'h0,        0,0,  5, 7, 32'hDEADBEEF, 32'h0,        0,1,1, 32'h0,        1));
        vecs.push_back(mk(0,1,1, 5,32'h00001111, 1,8,  5, 7, 32'h0,        32'h0,        0,0,0, 32'h0,        0));
        vecs.push_back(mk(1,0,0, 0,32'h0,        0,0,  5, 7, 32'h0,        32'h0,        0,0,0, 32'h0,        0));
        vecs.push_back(mk(1,0,0, 0,32'h0,        0,0,  5, 8, 32'h0,        32'h0,        0,0,0, 32'h0,        0));
        vecs.push_back(mk(1,0,1, 3,32'h12345678, 0,0,  1, 3, 32'h0,        32'h12345678, 0,0,0, 32'h0,        0));
        vecs.push_back(mk(1,0,0, 0,32'h0,        0,0,  3, 3, 32'h12345678, 32'h12345678, 0,0,0, 32'h12345678, 0));
        vecs.push_back(mk(1,0,1, 9,32'h00000001, 0,0,  0, 0, 32'h0,        32'h0,        0,0,0, 32'h0,        0));
        vecs.push_back(mk(1,0,1, 9,32'hA5A5A5A5, 0,0,  3, 9, 32'h12345678, 32'hA5A5A5A5, 0,0,0, 32'h00000001, 0));
        vecs.push_back(mk(1,0,0, 0,32'h0,        0,0,  9, 9, 32'hA5A5A5A5, 32'hA5A5A5A5, 0,0,0, 32'hA5A5A5A5, 0));
        vecs.push_back(mk(1,0,1, 0,32'hFFFFFFFF, 1,0,  0, 0, 32'h0,        32'h0,        0,0,0, 32'h0,        0));
        vecs.push_back(mk(1,0,0, 0,32'h0,        0,0,  0, 0, 32'h0,        32'h0,        0,0,0, 32'h0,        0));
        vecs.push_back(mk(1,0,0, 0,32'h0,        1,4,  4, 4, 32'h0,        32'h0,        0,0,0, 32'h0,        0));
        vecs.push_back(mk(1,0,0, 0,32'h0,        0,0,  4, 4, 32'h0,        32'h0,        1,1,1, 32'h0,        1));
        vecs.push_back(mk(1,0,1, 4,32'h00000077, 0,0,  4, 9, 32'h00000077, 32'hA5A5A5A5, 0,0,1, 32'hA5A5A5A5, 0));
        vecs.push_back(mk(1,0,0, 0,32'h0,        0,0,  4, 4, 32'h00000077, 32'h00000077, 0,0,0, 32'h00000077, 0));
        vecs.push_back(mk(1,0,0, 0,32'h0,        1,6,  6, 6, 32'h0,        32'h0,        0,0,0, 32'h0,        0));
        vecs.push_back(mk(1,0,1, 6,32'h00000055, 1,6,  6, 6, 32'h00000055, 32'h00000055, 0,0,1, 32'h0,        1));
        vecs.push_back(mk(1,0,0, 0,32'h0,        0,0,  6, 6, 32'h00000055, 32'h00000055, 1,1,1, 32'h00000055, 1));
        vecs.push_back(mk(1,0,1, 6,32'h00000066, 0,0,  6, 4, 32'h00000066, 32'h00000077, 0,0,1, 32'h00000077, 0));
        vecs.push_back(mk(1,0,0, 0,32'h0,        0,0,  6, 6, 32'h00000066, 32'h00000066, 0,0,0, 32'h00000066, 0));
        vecs.push_back(mk(1,0,1,10,32'hCAFE0001, 1,11,10,11, 32'hCAFE0001, 32'h0,        0,0,0, 32'h0,        0));
        vecs.push_back(mk(1,0,0, 0,32'h0,        0,0, 10,11, 32'hCAFE0001, 32'h0,        0,1,1, 32'h0,        1));
        vecs.push_back(mk(1,0,1,31,32'h80000001, 0,0, 31,10, 32'h80000001, 32'hCAFE0001, 0,0,1, 32'hCAFE0001, 0));
        vecs.push_back(mk(1,0,0, 0,32'h0,        0,0, 31,11, 32'h80000001, 32'h0,        0,1,1, 32'h0,        1));

        // Table: drive on the falling edge, check combinational outputs before the next rising edge.
        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].rst, vecs[k].we, vecs[k].aw, vecs[k].wd, vecs[k].res, vecs[k].ar,
                  vecs[k].ra1, vecs[k].ra2);
            #2;
            if (vecs[k].chk) begin
                cmp($sformatf("v%0d.DR1", k),     bus_b.DR1,            vecs[k].dr1);
                cmp($sformatf("v%0d.DR2", k),     bus_b.DR2,            vecs[k].dr2);
                cmp($sformatf("v%0d.Busy1", k),   32'(bus_b.Busy1),     32'(vecs[k].b1));
                cmp($sformatf("v%0d.Busy2", k),   32'(bus_b.Busy2),     32'(vecs[k].b2));
                cmp($sformatf("v%0d.AnyBusy", k), 32'(bus_b.AnyBusy),   32'(vecs[k].any));
                cmp($sformatf("v%0d.nob.DR2", k), bus_n.DR2,            vecs[k].dr2n);
                cmp($sformatf("v%0d.nob.Busy2", k), 32'(bus_n.Busy2),   32'(vecs[k].b2n));
            end
        end

        // Fill every register (r0 write must be ignored), then read all back.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 5'(i), pat(i), 1'b0, 5'(0), 5'(0), 5'(0));
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 5'(0), 32'h0, 1'b0, 5'(0), 5'(i), 5'(31 - i));
            #2;
            cmp($sformatf("fill.DR1[%0d]", i), bus_b.DR1, (i == 0) ? 32'h0 : pat(i));
            cmp($sformatf("fill.nob.DR2[%0d]", 31 - i), bus_n.DR2, (i == 31) ? 32'h0 : pat(31 - i));
        end

        // Reserve every register, confirm pending state, then reset clears everything.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 5'(0), 32'h0, 1'b1, 5'(i), 5'(0), 5'(0));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 5'(0), 32'h0, 1'b0, 5'(0), 5'(0), 5'(17));
        #2;
        cmp("resv.Busy1_r0", 32'(bus_b.Busy1), 32'h0);
        cmp("resv.Busy2_r17", 32'(bus_b.Busy2), 32'h1);
        cmp("resv.AnyBusy", 32'(bus_b.AnyBusy), 32'h1);
        @(negedge clk);
        drive(1'b1, 1'b1, 5'(12), 32'hFFFF0000, 1'b1, 5'(13), 5'(0), 5'(0));
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 5'(0), 32'h0, 1'b0, 5'(0), 5'(i), 5'(i));
            #2;
            cmp($sformatf("rst.DR1[%0d]", i), bus_b.DR1, 32'h0);
            cmp($sformatf("rst.Busy2[%0d]", i), 32'(bus_b.Busy2), 32'h0);
        end
        cmp("rst.AnyBusy", 32'(bus_b.AnyBusy), 32'h0);
        cmp("rst.nob.AnyBusy", 32'(bus_n.AnyBusy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/banco_reg_sb.md
Name: banco_reg_sb

Overview:
- Parametrised successor to the single-cycle MIPS register bank.
- Holds NREG general-purpose registers with two asynchronous read ports and one clocked write port.
- Optional register-0 hardwiring and write-to-read bypass.
- Adds a per-register pending (scoreboard) bit so a pipelined datapath can detect RAW hazards on in-flight loads and results.

Parameters:
- WIDTH, 32, data bits per register.
- NREG, 32, number of registers; power of two, minimum 2.
- AW_BITS, 5, address width; equals log2(NREG).
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes, and is never marked pending.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- RegWrite  input  1  write enable.
- AW  input  AW_BITS  write address.
- WriteData  input  WIDTH  write data.
- RA1  input  AW_BITS  read address, port 1.
- RA2  input  AW_BITS  read address, port 2.
- DR1  output  WIDTH  read data, port 1 (combinational).
- DR2  output  WIDTH  read data, port 2 (combinational).
- Reserve  input  1  mark register AR pending.
- AR  input  AW_BITS  reservation address.
- Busy1  output  1  pending bit of RA1 (combinational).
- Busy2  output  1  pending bit of RA2 (combinational).
- AnyBusy  output  1  OR of all pending bits.

Behaviour:
- Single clock domain (clk); reset is synchronous, active-high (rst); all state updates on the rising edge of clk.
- Reset:
  - rst=1 at a clock edge clears all NREG registers to 0 and all pending bits to 0.
  - rst overrides RegWrite and Reserve in the same cycle.
  - Outputs after reset: DR1=DR2=0, Busy1=Busy2=AnyBusy=0.
  - Reset asserted mid-operation discards any write or reservation presented in that cycle.
- Write:
  - If RegWrite=1 and not (ZERO_REG=1 and AW=0), Reg[AW] <= WriteData at the edge.
  - The pending bit of AW is cleared at the same edge.
- Read:
  - DR1 = Reg[RA1] and DR2 = Reg[RA2], combinational with zero-cycle latency.
  - With ZERO_REG=1 and RAx=0, DRx = 0 regardless of array contents.
- Bypass (BYPASS=1):
  - If RegWrite=1, AW=RAx, and AW is writable, then DRx = WriteData in the same cycle.
  - Busyx reads 0 in that case, since the write retires the hazard.
  - With BYPASS=0, DRx shows the old value until after the edge.
- Reservation:
  - If Reserve=1 and not (ZERO_REG=1 and AR=0), pending[AR] <= 1 at the edge.
  - A reservation is visible on Busyx starting the cycle after the edge.
- Simultaneous write and reserve to the same address: the reservation wins, so pending stays 1 and the data is written. This models a new in-flight producer following an older one.
- Write and reserve to different addresses: both take effect independently.
- Write to a non-pending register: data is written; pending stays 0.
- Address range: all AW_BITS codes are valid; there is no out-of-range case because NREG = 2^AW_BITS.
- Widths: no arithmetic is performed; WriteData is stored bit-exact.
- Initial contents: no file load; contents are defined only after the first reset. Benches must reset first.

Test Plan:
- Reset with dirty state: write 0xDEADBEEF to r5, reserve r7, then assert rst for 1 cycle -> DR1(RA1=5)=0, Busy1(RA1=7)=0, AnyBusy=0.
- Write/read, no bypass case: write 0x12345678 to r3, next cycle RA1=RA2=3 -> DR1=DR2=0x12345678.
- Same-cycle bypass: with r9=0x1, present RegWrite=1, AW=9, WriteData=0xA5A5A5A5, RA2=9 -> DR2=0xA5A5A5A5 in the same cycle. Repeat with BYPASS=0 -> DR2=0x1, then 0xA5A5A5A5 after the edge.
- Zero register: write 0xFFFFFFFF to r0 and reserve r0 -> DR1(RA1=0)=0, Busy1=0, AnyBusy=0.
- Scoreboard lifecycle: reserve r4 -> Busy1(RA1=4)=1 from the next cycle and AnyBusy=1. Write r4=0x77 -> Busy1=0 in the bypass cycle and after the edge; DR1=0x77.
- Write/reserve collision: r6 pending; same cycle RegWrite AW=6 data 0x55 with Reserve AR=6 -> after the edge DR1(RA1=6)=0x55 and Busy1=1. A later write clears Busy1.
